rsa_stream_mm: RTL and testbench

//  Output-stationary X-by-Y systolic matrix multiplier (C = A*B, or C += A*B) with runtime inner dimension n.

---
 rtl/rsa_stream_mm_if.sv | 32 +++
 rtl/rsa_stream_mm.sv | 250 +++++++++++++++++++++++++
 tb/tb_rsa_stream_mm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_stream_mm_if.sv
// Stream bundle for rsa_stream_mm.
//  Xin_*  : A column beats, one k-step per beat (A[i][k] in bits [i*IN_LEN +: IN_LEN])
//  Yin_*  : B row beats, one k-step per beat (B[k][j] in bits [j*IN_LEN +: IN_LEN])
//  out_*  : serial result drain, row-major, out_last with C[X-1][Y-1]
// master = operand/result-consumer side, slave = the multiplier.
interface rsa_stream_mm_if #(
  parameter int unsigned X       = 3,
  parameter int unsigned Y       = 3,
  parameter int unsigned IN_LEN  = 4,
  parameter int unsigned OUT_LEN = 8
);
  logic                  Xin_val;
  logic                  Xin_rdy;
  logic [X*IN_LEN-1:0]   Xin_data;
  logic                  Yin_val;
  logic                  Yin_rdy;
  logic [Y*IN_LEN-1:0]   Yin_data;
  logic                  out_val;
  logic                  out_rdy;
  logic [OUT_LEN-1:0]    out_data;
  logic                  out_last;

  modport master (
    output Xin_val, Xin_data, Yin_val, Yin_data, out_rdy,
    input  Xin_rdy, Yin_rdy, out_val, out_data, out_last
  );

  modport slave (
    input  Xin_val, Xin_data, Yin_val, Yin_data, out_rdy,
    output Xin_rdy, Yin_rdy, out_val, out_data, out_last
  );
endinterface

// File: rtl/rsa_stream_mm.sv
// Output-stationary X-by-Y systolic matrix multiplier, C = A*B or C += A*B,
// with runtime inner dimension n, signed/unsigned mode and saturation.
// Ports:
//  clk, sys_rst_n   clock, synchronous active-low reset
//  start, cfg_*     job start pulse and configuration sampled with it in IDLE
//  cfg_err          1-cycle pulse when a start is rejected (cfg_n==0 or >N_MAX)
//  busy             high whenever the FSM is not IDLE
//  bus (slave)      A/B operand streams (join handshake) and serial result drain
module rsa_stream_mm #(
  parameter int unsigned X       = 3,
  parameter int unsigned Y       = 3,
  parameter int unsigned N_MAX   = 8,
  parameter int unsigned IN_LEN  = 4,
  parameter int unsigned OUT_LEN = 8,
  parameter int unsigned N_W     = $clog2(N_MAX + 1)
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  input  logic           start,
  input  logic [N_W-1:0] cfg_n,
  input  logic           cfg_acc,
  input  logic           cfg_signed,
  output logic           cfg_err,
  output logic           busy,
  rsa_stream_mm_if.slave bus
);
  localparam int unsigned ACC_LEN = 2*IN_LEN + $clog2(N_MAX) + 1;
  localparam int unsigned P_LEN   = 2*IN_LEN + 2;
  localparam int unsigned FL_W    = $clog2(X + Y);
  localparam int unsigned RI_W    = (X > 1) ? $clog2(X) : 1;
  localparam int unsigned CJ_W    = (Y > 1) ? $clog2(Y) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t              state;
  logic [N_W-1:0]      n_q, kcnt;
  logic                sgn_q;
  logic [FL_W-1:0]     fcnt;
  logic [RI_W-1:0]     ri, ri_n;
  logic [CJ_W-1:0]     cj, cj_n;
  logic                last_el, fire, cfg_ok, clr;

  logic [IN_LEN-1:0]   a_skd [X];
  logic [X-1:0]        a_skv;
  logic [IN_LEN-1:0]   b_skd [Y];
  logic [IN_LEN-1:0]   a_pe  [X][Y];
  logic [IN_LEN-1:0]   b_pe  [X][Y];
  logic                v_pe  [X][Y];
  logic [ACC_LEN-1:0]  acc   [X][Y];

  // Saturating multiply-accumulate; the sum is formed 2 bits wider than the
  // accumulator so both signed and unsigned overflow are detectable.
  function automatic logic [ACC_LEN-1:0] mac(input logic [ACC_LEN-1:0] a_acc,
                                             input logic [IN_LEN-1:0] a,
                                             input logic [IN_LEN-1:0] b,
                                             input logic sg);
    logic signed [IN_LEN:0]    ax, bx;
    logic signed [P_LEN-1:0]   p;
    logic signed [ACC_LEN+1:0] s, hi, lo;
    ax = $signed({sg & a[IN_LEN-1], a});
    bx = $signed({sg & b[IN_LEN-1], b});
    p  = $signed({{(P_LEN-IN_LEN-1){ax[IN_LEN]}}, ax}) *
         $signed({{(P_LEN-IN_LEN-1){bx[IN_LEN]}}, bx});
    s  = $signed({{2{sg & a_acc[ACC_LEN-1]}}, a_acc}) +
         $signed({{(ACC_LEN+2-P_LEN){p[P_LEN-1]}}, p});
    if (sg) begin
      hi = $signed({3'b000, {(ACC_LEN-1){1'b1}}});
      lo = $signed({3'b111, {(ACC_LEN-1){1'b0}}});
    end else begin
      hi = $signed({2'b00, {ACC_LEN{1'b1}}});
      lo = '0;
    end
    if (s > hi)      return hi[ACC_LEN-1:0];
    else if (s < lo) return lo[ACC_LEN-1:0];
    else             return s[ACC_LEN-1:0];
  endfunction

  function automatic logic [OUT_LEN-1:0] sat_out(input logic [ACC_LEN-1:0] x,
                                                 input logic sg);
    logic signed [ACC_LEN:0] v, hi, lo;
    v = $signed({sg & x[ACC_LEN-1], x});
    if (sg) begin
      hi = $signed({{(ACC_LEN+2-OUT_LEN){1'b0}}, {(OUT_LEN-1){1'b1}}});
      lo = $signed({{(ACC_LEN+2-OUT_LEN){1'b1}}, {(OUT_LEN-1){1'b0}}});
    end else begin
      hi = $signed({{(ACC_LEN+1-OUT_LEN){1'b0}}, {OUT_LEN{1'b1}}});
      lo = '0;
    end
    if (v > hi)      return hi[OUT_LEN-1:0];
    else if (v < lo) return lo[OUT_LEN-1:0];
    else             return v[OUT_LEN-1:0];
  endfunction

  assign bus.Xin_rdy = (state == LOAD) & bus.Yin_val;
  assign bus.Yin_rdy = (state == LOAD) & bus.Xin_val;
  assign fire        = (state == LOAD) & bus.Xin_val & bus.Yin_val;
  assign cfg_ok      = (cfg_n != '0) && (cfg_n <= N_W'(N_MAX));
  assign clr         = (state == IDLE) && start && cfg_ok && !cfg_acc;

  always_comb begin
    last_el = (ri == RI_W'(X-1)) && (cj == CJ_W'(Y-1));
    ri_n    = ri;
    cj_n    = cj + CJ_W'(1);
    if (cj == CJ_W'(Y-1)) begin
      cj_n = '0;
      ri_n = ri + RI_W'(1);
    end
  end

  // Input skew: row i of A is delayed i cycles, column j of B j cycles, so
  // A[i][k] and B[k][j] meet in PE(i,j) i+j cycles after their beat.
  for (genvar gi = 0; gi < X; gi++) begin : g_askew
    if (gi == 0) begin : g_direct
      assign a_skd[gi] = bus.Xin_data[gi*IN_LEN +: IN_LEN];
      assign a_skv[gi] = fire;
    end else begin : g_dly
      logic [IN_LEN-1:0] d [gi];
      logic [gi-1:0]     v;
      always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
          for (int unsigned s = 0; s < gi; s++) d[s] <= '0;
          v <= '0;
        end else begin
          d[0] <= bus.Xin_data[gi*IN_LEN +: IN_LEN];
          v[0] <= fire;
          for (int unsigned s = 1; s < gi; s++) begin
            d[s] <= d[s-1];
            v[s] <= v[s-1];
          end
        end
      end
      assign a_skd[gi] = d[gi-1];
      assign a_skv[gi] = v[gi-1];
    end
  end

  for (genvar gj = 0; gj < Y; gj++) begin : g_bskew
    if (gj == 0) begin : g_direct
      assign b_skd[gj] = bus.Yin_data[gj*IN_LEN +: IN_LEN];
    end else begin : g_dly
      logic [IN_LEN-1:0] d [gj];
      always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
          for (int unsigned s = 0; s < gj; s++) d[s] <= '0;
        end else begin
          d[0] <= bus.Yin_data[gj*IN_LEN +: IN_LEN];
          for (int unsigned s = 1; s < gj; s++) d[s] <= d[s-1];
        end
      end
      assign b_skd[gj] = d[gj-1];
    end
  end

  // PE grid: A flows right, B flows down; the valid bit travels with A.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < X; i++)
        for (int unsigned j = 0; j < Y; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          v_pe[i][j] <= 1'b0;
          acc[i][j]  <= '0;
        end
    end else begin
      for (int unsigned i = 0; i < X; i++) begin
        a_pe[i][0] <= a_skd[i];
        v_pe[i][0] <= a_skv[i];
        for (int unsigned j = 1; j < Y; j++) begin
          a_pe[i][j] <= a_pe[i][j-1];
          v_pe[i][j] <= v_pe[i][j-1];
        end
      end
      for (int unsigned j = 0; j < Y; j++) begin
        b_pe[0][j] <= b_skd[j];
        for (int unsigned i = 1; i < X; i++) b_pe[i][j] <= b_pe[i-1][j];
      end
      for (int unsigned i = 0; i < X; i++)
        for (int unsigned j = 0; j < Y; j++)
          if (clr)
            acc[i][j] <= '0;
          else if (v_pe[i][j])
            acc[i][j] <= mac(acc[i][j], a_pe[i][j], b_pe[i][j], sgn_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      n_q          <= '0;
      sgn_q        <= 1'b0;
      kcnt         <= '0;
      fcnt         <= '0;
      ri           <= '0;
      cj           <= '0;
      bus.out_val  <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_data <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (cfg_ok) begin
            n_q   <= cfg_n;
            sgn_q <= cfg_signed;
            kcnt  <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        LOAD: if (fire) begin
          if (kcnt == n_q - N_W'(1)) begin
            fcnt  <= '0;
            state <= FLUSH;
          end else begin
            kcnt <= kcnt + N_W'(1);
          end
        end
        // X+Y-1 cycles lets the last beat reach PE(X-1,Y-1) and accumulate.
        FLUSH: if (fcnt == FL_W'(X+Y-2)) begin
          ri           <= '0;
          cj           <= '0;
          bus.out_data <= sat_out(acc[0][0], sgn_q);
          bus.out_last <= (X == 1) && (Y == 1);
          bus.out_val  <= 1'b1;
          state        <= DRAIN;
        end else begin
          fcnt <= fcnt + FL_W'(1);
        end
        DRAIN: if (bus.out_rdy) begin
          if (last_el) begin
            bus.out_val  <= 1'b0;
            bus.out_last <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            ri           <= ri_n;
            cj           <= cj_n;
            bus.out_data <= sat_out(acc[ri_n][cj_n], sgn_q);
            bus.out_last <= (ri_n == RI_W'(X-1)) && (cj_n == CJ_W'(Y-1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_stream_mm.sv
// Self-checking bench for rsa_stream_mm: directed jobs plus randomized
// data/gaps, checked against an integer matrix-multiply reference model.
module tb_rsa_stream_mm;
  localparam int unsigned X = 3, Y = 3, N_MAX = 8, IN_LEN = 4, OUT_LEN = 8;
  localparam int unsigned N_W = $clog2(N_MAX + 1);
  localparam int ACC_LEN = 2*IN_LEN + $clog2(N_MAX) + 1;

  logic clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0;
  logic cfg_acc = 1'b0, cfg_signed = 1'b0;
  logic [N_W-1:0] cfg_n = '0;
  logic cfg_err, busy;

  rsa_stream_mm_if #(.X(X), .Y(Y), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) bus ();

  rsa_stream_mm #(.X(X), .Y(Y), .N_MAX(N_MAX), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .cfg_n(cfg_n),
    .cfg_acc(cfg_acc), .cfg_signed(cfg_signed), .cfg_err(cfg_err), .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cycles = 0;
  always @(posedge clk) cycles <= cycles + 1;

  int n_cmp = 0, n_err = 0;
  logic [IN_LEN-1:0] am [X][N_MAX];
  logic [IN_LEN-1:0] bm [N_MAX][Y];
  int cm [X][Y];

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int opv(input logic [IN_LEN-1:0] v, input bit sg);
    if (sg && v[IN_LEN-1]) return int'(v) - (1 << IN_LEN);
    return int'(v);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  // C (+)= A*B with per-step accumulator saturation.
  task automatic model_job(input int n, input bit acc, input bit sg);
    int lo, hi;
    lo = sg ? -(1 << (ACC_LEN-1)) : 0;
    hi = sg ? (1 << (ACC_LEN-1)) - 1 : (1 << ACC_LEN) - 1;
    if (!acc) foreach (cm[i, j]) cm[i][j] = 0;
    for (int k = 0; k < n; k++)
      foreach (cm[i, j])
        cm[i][j] = clampi(cm[i][j] + opv(am[i][k], sg) * opv(bm[k][j], sg), lo, hi);
  endtask

  function automatic int expo(input int v, input bit sg);
    int c;
    c = sg ? clampi(v, -(1 << (OUT_LEN-1)), (1 << (OUT_LEN-1)) - 1)
           : clampi(v, 0, (1 << OUT_LEN) - 1);
    return c & ((1 << OUT_LEN) - 1);
  endfunction

  task automatic run_job(input int n, input bit acc, input bit sg, input bit gaps,
                         input bit stall, input bit inject, input bit chk_lat,
                         input int abort_after);
    int k, tmo, idx;
    int unsigned tlast;
    bit fire, injected, inj_now, held, first, rdy;
    logic [X*IN_LEN-1:0] xd;
    logic [Y*IN_LEN-1:0] yd;
    logic [OUT_LEN-1:0] hd;
    logic hl;
    model_job(n, acc, sg);
    cfg_n = N_W'(n); cfg_acc = acc; cfg_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    k = 0; tmo = 0; injected = 0; inj_now = 0; tlast = 0;
    while (k < n && tmo < 500) begin
      for (int i = 0; i < X; i++) xd[i*IN_LEN +: IN_LEN] = am[i][k];
      for (int j = 0; j < Y; j++) yd[j*IN_LEN +: IN_LEN] = bm[k][j];
      bus.Xin_data = xd; bus.Yin_data = yd;
      if (!bus.Xin_val) bus.Xin_val = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bus.Yin_val) bus.Yin_val = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && k == 1 && !injected) begin
        start = 1'b1; cfg_n = 1; cfg_acc = 1'b1; cfg_signed = !sg;
        injected = 1; inj_now = 1;
      end
      #1;
      fire = bus.Xin_val && bus.Yin_val && bus.Xin_rdy && bus.Yin_rdy;
      @(posedge clk); #1;
      tmo++;
      if (inj_now) begin
        start = 1'b0; cfg_n = N_W'(n); cfg_acc = acc; cfg_signed = sg; inj_now = 0;
        check("start_in_load_no_err", cfg_err, 0);
        check("start_in_load_busy", busy, 1);
      end
      if (fire) begin
        k++; tlast = cycles;
        bus.Xin_val = 1'b0; bus.Yin_val = 1'b0;
      end
    end
    bus.Xin_val = 1'b0; bus.Yin_val = 1'b0;
    check("beats_accepted", k, n);
    idx = 0; tmo = 0; held = 0; first = chk_lat;
    while (idx < X*Y && tmo < 200) begin
      rdy = stall ? (tmo % 2 == 0) : 1'b1;
      bus.out_rdy = rdy;
      if (bus.out_val) begin
        if (first) begin
          check("out_val_latency", cycles - tlast, X + Y - 1);
          first = 0;
        end
        if (held) begin
          check("stall_hold_data", bus.out_data, hd);
          check("stall_hold_last", bus.out_last, hl);
        end
        if (rdy) begin
          check("out_data", bus.out_data, expo(cm[idx / Y][idx % Y], sg));
          check("out_last", bus.out_last, idx == X*Y - 1);
          idx++; held = 0;
        end else begin
          held = 1; hd = bus.out_data; hl = bus.out_last;
        end
      end
      @(posedge clk); #1;
      tmo++;
      if (abort_after != 0 && idx == abort_after) begin
        sys_rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_val", bus.out_val, 0);
        check("abort_busy", busy, 0);
        sys_rst_n = 1'b1;
        bus.out_rdy = 1'b0;
        return;
      end
    end
    bus.out_rdy = 1'b0;
    check("drain_count", idx, X*Y);
    check("idle_out_val", bus.out_val, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic load_ident();
    for (int i = 0; i < X; i++)
      for (int k = 0; k < N_MAX; k++) am[i][k] = (i == k) ? 4'd1 : 4'd0;
    for (int k = 0; k < N_MAX; k++)
      for (int j = 0; j < Y; j++) bm[k][j] = IN_LEN'(k*Y + j + 1);
  endtask

  task automatic fill(input logic [IN_LEN-1:0] av, input logic [IN_LEN-1:0] bv);
    foreach (am[i, k]) am[i][k] = av;
    foreach (bm[k, j]) bm[k][j] = bv;
  endtask

  task automatic bad_start(input int n);
    cfg_n = N_W'(n); cfg_acc = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_err_busy", busy, 0);
    @(posedge clk); #1;
    check("cfg_err_clear", cfg_err, 0);
    check("cfg_err_busy2", busy, 0);
  endtask

  initial begin
    bus.Xin_val = 1'b0; bus.Yin_val = 1'b1; bus.out_rdy = 1'b0;
    bus.Xin_data = '0; bus.Yin_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_xin_rdy", bus.Xin_rdy, 0);
    bus.Yin_val = 1'b0;
    sys_rst_n = 1'b1;
    @(posedge clk); #1;

    // identity A, B = 1..9, with latency check
    load_ident();
    run_job(3, 0, 0, 0, 0, 0, 1, 0);

    // saturation corners
    fill(4'hF, 4'hF);  run_job(3, 0, 0, 0, 0, 0, 0, 0);
    fill(4'h8, 4'h8);  run_job(3, 0, 1, 0, 0, 0, 0, 0);
    fill(4'h8, 4'h7);  run_job(3, 0, 1, 0, 0, 0, 0, 0);

    // accumulate chain, then fresh job
    load_ident();
    run_job(3, 0, 0, 0, 0, 0, 0, 0);
    run_job(3, 1, 0, 0, 0, 0, 0, 0);
    run_job(3, 0, 0, 0, 0, 0, 0, 0);

    // random data: gap-free, then same data with gaps and stalls
    foreach (am[i, k]) am[i][k] = IN_LEN'($urandom);
    foreach (bm[k, j]) bm[k][j] = IN_LEN'($urandom);
    run_job(N_MAX, 0, 0, 0, 0, 0, 1, 0);
    run_job(N_MAX, 0, 0, 1, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      foreach (am[i, k]) am[i][k] = IN_LEN'($urandom);
      foreach (bm[k, j]) bm[k][j] = IN_LEN'($urandom);
      run_job(int'($urandom_range(1, N_MAX)), 0, r[0], 1, 1, 0, 0, 0);
    end

    // reset after the 4th output handshake, then a clean job
    load_ident();
    run_job(3, 0, 0, 0, 0, 0, 0, 4);
    run_job(3, 0, 0, 0, 0, 0, 0, 0);

    // rejected configs and start during LOAD
    bad_start(0);
    bad_start(N_MAX + 1);
    run_job(3, 0, 0, 1, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
